// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with seven-region address decode.
// One transaction at a time: select a device, wait for its ack or a timeout, then report done to the master.
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int NUM_DEV        = 7
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_m0_req,
    input  logic                    i_m0_we,
    input  logic [31:0]             i_m0_addr,
    input  logic [31:0]             i_m0_wdata,
    input  logic [3:0]              i_m0_be,
    output logic [31:0]             o_m0_rdata,
    output logic                    o_m0_done,
    output logic                    o_m0_err,
    input  logic                    i_m1_req,
    input  logic                    i_m1_we,
    input  logic [31:0]             i_m1_addr,
    input  logic [31:0]             i_m1_wdata,
    input  logic [3:0]              i_m1_be,
    output logic [31:0]             o_m1_rdata,
    output logic                    o_m1_done,
    output logic                    o_m1_err,
    output logic [31:0]             o_addr,
    output logic [31:0]             o_wdata,
    output logic                    o_we,
    output logic [3:0]              o_be,
    output logic [NUM_DEV-1:0]      o_sel,
    input  logic [NUM_DEV-1:0]      i_ack,
    input  logic [32*NUM_DEV-1:0]   i_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t               r_state, w_state_next;
    logic                 r_rr_last, w_rr_last_next;   // 0 = M0, 1 = M1
    logic                 r_gnt, w_gnt_next;
    logic                 r_err, w_err_next;
    logic [7:0]           r_cnt, w_cnt_next;
    logic [31:0]          r_rdata, w_rdata_next;
    logic [31:0]          r_addr, w_addr_next;
    logic [31:0]          r_wdata, w_wdata_next;
    logic                 r_we, w_we_next;
    logic [3:0]           r_be, w_be_next;
    logic [NUM_DEV-1:0]   r_sel, w_sel_next;

    logic                 w_req_any;
    logic                 w_grant_m1;
    logic [31:0]          w_req_addr;
    logic [NUM_DEV-1:0]   w_dec_sel;
    logic                 w_dec_mapped;
    logic                 w_ack_hit;
    logic                 w_timeout;
    logic [31:0]          w_rdata_part [NUM_DEV];
    logic [31:0]          w_rdata_mux;

    // On a tie M1 wins only when M0 was the last master served.
    assign w_req_any  = i_m0_req | i_m1_req;
    assign w_grant_m1 = i_m1_req & (~i_m0_req | ~r_rr_last);
    assign w_req_addr = w_grant_m1 ? i_m1_addr : i_m0_addr;

    assign w_dec_sel[0] = (w_req_addr < 32'h0000_2000);
    genvar gi;
    generate
        for (gi = 1; gi < NUM_DEV; gi++) begin : g_dec
            assign w_dec_sel[gi] = (w_req_addr[31:28] == 4'(gi));
        end
        for (gi = 0; gi < NUM_DEV; gi++) begin : g_rmux
            assign w_rdata_part[gi] = i_rdata[32*gi +: 32] & {32{r_sel[gi]}};
        end
    endgenerate
    assign w_dec_mapped = |w_dec_sel;

    always_comb begin
        w_rdata_mux = '0;
        for (int k = 0; k < NUM_DEV; k++) begin
            w_rdata_mux = w_rdata_mux | w_rdata_part[k];
        end
    end

    assign w_ack_hit = |(i_ack & r_sel);
    assign w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_rr_last <= 1'b1;
            r_gnt     <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_sel     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_rr_last <= w_rr_last_next;
            r_gnt     <= w_gnt_next;
            r_err     <= w_err_next;
            r_cnt     <= w_cnt_next;
            r_rdata   <= w_rdata_next;
            r_addr    <= w_addr_next;
            r_wdata   <= w_wdata_next;
            r_we      <= w_we_next;
            r_be      <= w_be_next;
            r_sel     <= w_sel_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_rr_last_next = r_rr_last;
        w_gnt_next     = r_gnt;
        w_err_next     = r_err;
        w_cnt_next     = r_cnt;
        w_rdata_next   = r_rdata;
        w_addr_next    = r_addr;
        w_wdata_next   = r_wdata;
        w_we_next      = r_we;
        w_be_next      = r_be;
        w_sel_next     = r_sel;
        case (r_state)
            ST_IDLE: begin
                w_sel_next = '0;
                if (w_req_any) begin
                    w_gnt_next     = w_grant_m1;
                    w_rr_last_next = w_grant_m1;
                    w_addr_next    = w_req_addr;
                    w_wdata_next   = w_grant_m1 ? i_m1_wdata : i_m0_wdata;
                    w_we_next      = w_grant_m1 ? i_m1_we    : i_m0_we;
                    w_be_next      = w_grant_m1 ? i_m1_be    : i_m0_be;
                    w_rdata_next   = '0;
                    if (w_dec_mapped) begin
                        w_sel_next   = w_dec_sel;
                        w_cnt_next   = '0;
                        w_err_next   = 1'b0;
                        w_state_next = ST_ACCESS;
                    end else begin
                        w_err_next   = 1'b1;
                        w_state_next = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                if (w_ack_hit) begin
                    w_rdata_next = w_rdata_mux;
                    w_err_next   = 1'b0;
                    w_sel_next   = '0;
                    w_state_next = ST_RESP;
                end else if (w_timeout) begin
                    w_rdata_next = '0;
                    w_err_next   = 1'b1;
                    w_sel_next   = '0;
                    w_state_next = ST_RESP;
                end else begin
                    w_cnt_next = 8'(r_cnt + 8'd1);
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_sel_next   = '0;
            end
        endcase
    end

    // Read data is only meaningful for a successful read; writes and errors return zero.
    assign o_m0_done  = (r_state == ST_RESP) & ~r_gnt;
    assign o_m1_done  = (r_state == ST_RESP) &  r_gnt;
    assign o_m0_err   = o_m0_done & r_err;
    assign o_m1_err   = o_m1_done & r_err;
    assign o_m0_rdata = (o_m0_done & ~r_err & ~r_we) ? r_rdata : 32'h0;
    assign o_m1_rdata = (o_m1_done & ~r_err & ~r_we) ? r_rdata : 32'h0;

    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;
    assign o_we    = r_we;
    assign o_be    = r_be;
    assign o_sel   = r_sel;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter: the driver predicts each response from the
// arbitration/decode rules and queues it; a monitor pops and compares whenever done appears.
module tb_bus_arbiter;
    localparam int T = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_m0_req, i_m0_we, i_m1_req, i_m1_we;
    logic [31:0]   i_m0_addr, i_m0_wdata, i_m1_addr, i_m1_wdata;
    logic [3:0]    i_m0_be, i_m1_be;
    logic [31:0]   o_m0_rdata, o_m1_rdata;
    logic          o_m0_done, o_m0_err, o_m1_done, o_m1_err;
    logic [31:0]   o_addr, o_wdata;
    logic          o_we;
    logic [3:0]    o_be;
    logic [6:0]    o_sel;
    logic [6:0]    i_ack;
    logic [223:0]  i_rdata;

    bus_arbiter #(.TIMEOUT_CYCLES(T), .NUM_DEV(7)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m0_req(i_m0_req), .i_m0_we(i_m0_we), .i_m0_addr(i_m0_addr),
        .i_m0_wdata(i_m0_wdata), .i_m0_be(i_m0_be),
        .o_m0_rdata(o_m0_rdata), .o_m0_done(o_m0_done), .o_m0_err(o_m0_err),
        .i_m1_req(i_m1_req), .i_m1_we(i_m1_we), .i_m1_addr(i_m1_addr),
        .i_m1_wdata(i_m1_wdata), .i_m1_be(i_m1_be),
        .o_m1_rdata(o_m1_rdata), .o_m1_done(o_m1_done), .o_m1_err(o_m1_err),
        .o_addr(o_addr), .o_wdata(o_wdata), .o_we(o_we), .o_be(o_be),
        .o_sel(o_sel), .i_ack(i_ack), .i_rdata(i_rdata)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int          m;
        logic        err;
        logic [31:0] rdata;
        int          done_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rr_last = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Device index for an address, -1 when unmapped.
    function automatic int decode(input logic [31:0] a);
        if (a < 32'h2000) return 0;
        if (a >= 32'h1000_0000 && a < 32'h7000_0000) return int'(a / 32'h1000_0000);
        return -1;
    endfunction

    task automatic rand_rdata();
        for (int k = 0; k < 7; k++) i_rdata[32*k +: 32] = $urandom;
    endtask

    task automatic scramble_payload();
        i_m0_addr = $urandom; i_m0_wdata = $urandom; i_m0_we = 1'($urandom); i_m0_be = 4'($urandom);
        i_m1_addr = $urandom; i_m1_wdata = $urandom; i_m1_we = 1'($urandom); i_m1_be = 4'($urandom);
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge i_clk) begin
        int   m;
        exp_t e;
        if (o_m0_done || o_m1_done) begin
            m = o_m0_done ? 0 : 1;
            chk("single_done", 32'(o_m0_done & o_m1_done), 32'h0);
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done for M%0d at cycle %0d, required none", m, cyc);
            end else begin
                e = sb.pop_front();
                $display("[TB] txn M%0d err=%0d rdata=%h cycle=%0d", m, (m ? o_m1_err : o_m0_err),
                         (m ? o_m1_rdata : o_m0_rdata), cyc);
                chk("granted_master", 32'(m), 32'(e.m));
                chk("err", 32'(m ? o_m1_err : o_m0_err), 32'(e.err));
                chk("rdata", m ? o_m1_rdata : o_m0_rdata, e.rdata);
                chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
                chk("other_err", 32'(m ? o_m0_err : o_m1_err), 32'h0);
                chk("other_rdata", m ? o_m0_rdata : o_m1_rdata, 32'h0);
            end
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk); #1;
            i_m0_req = 1'b0; i_m1_req = 1'b0;
            scramble_payload();
            rand_rdata();
            i_ack = 7'($urandom);
            @(negedge i_clk);
            chk("idle_sel", 32'(o_sel), 32'h0);
        end
    endtask

    // Issues one request in the next cycle (DUT must be in IDLE) and predicts its outcome.
    task automatic issue(input logic r0, input logic r1, input logic we0, input logic we1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [3:0] b0, input logic [3:0] b1,
                         input int ack_d, input int noise_k, input logic [31:0] ack_val,
                         input logic hold);
        int          m, dev, done_c, g;
        logic [31:0] la, lw;
        logic        lwe;
        logic [3:0]  lb;
        logic [6:0]  own, exp_sel;
        exp_t        e;
        @(posedge i_clk); #1;
        g = cyc;
        i_m0_req = r0; i_m0_we = we0; i_m0_addr = a0; i_m0_wdata = d0; i_m0_be = b0;
        i_m1_req = r1; i_m1_we = we1; i_m1_addr = a1; i_m1_wdata = d1; i_m1_be = b1;
        i_ack = 7'($urandom);
        rand_rdata();

        m = (r0 && r1) ? (1 - rr_last) : (r1 ? 1 : 0);
        rr_last = m;
        la  = m ? a1 : a0;
        lw  = m ? d1 : d0;
        lwe = m ? we1 : we0;
        lb  = m ? b1 : b0;
        dev = decode(la);
        own = (dev >= 0) ? (7'b1 << dev) : 7'b0;
        if (dev < 0) begin
            e.err = 1'b1; e.rdata = 32'h0; done_c = g + 1;
        end else if (ack_d < T) begin
            e.err = 1'b0; e.rdata = lwe ? 32'h0 : ack_val; done_c = g + 2 + ack_d;
        end else begin
            e.err = 1'b1; e.rdata = 32'h0; done_c = g + T + 1;
        end
        e.m = m;
        e.done_cyc = done_c;
        sb.push_back(e);

        for (int k = 0; g + 1 + k <= done_c; k++) begin
            @(posedge i_clk); #1;
            if (!hold) begin
                i_m0_req = 1'($urandom);
                i_m1_req = 1'($urandom);
            end
            scramble_payload();
            rand_rdata();
            i_ack = '0;
            if (g + 1 + k < done_c) begin
                if (k == noise_k)
                    i_ack = (7'($urandom) | (7'b1 << ((dev + 4) % 7))) & ~own;
                if (k == ack_d) begin
                    i_ack[dev] = 1'b1;
                    i_rdata[32*dev +: 32] = ack_val;
                end
            end else begin
                i_ack = 7'($urandom);
            end
            @(negedge i_clk);
            exp_sel = (g + 1 + k < done_c) ? own : 7'b0;
            chk("sel", 32'(o_sel), 32'(exp_sel));
            if (k == 0) begin
                chk("o_addr", o_addr, la);
                chk("o_wdata", o_wdata, lw);
                chk("o_we", 32'(o_we), 32'(lwe));
                chk("o_be", 32'(o_be), 32'(lb));
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        int          cat, ackd, gap;
        logic        r0, r1, hold;

        i_rst = 1'b1;
        i_m0_req = 1'b0; i_m1_req = 1'b0;
        i_m0_we = 1'b0; i_m1_we = 1'b0;
        i_m0_addr = '0; i_m1_addr = '0; i_m0_wdata = '0; i_m1_wdata = '0;
        i_m0_be = '0; i_m1_be = '0;
        i_ack = '0; i_rdata = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_sel", 32'(o_sel), 32'h0);
        chk("rst_addr", o_addr, 32'h0);
        chk("rst_wdata", o_wdata, 32'h0);
        chk("rst_we_be", {27'h0, o_we, o_be}, 32'h0);
        chk("rst_done", {30'h0, o_m0_done, o_m1_done}, 32'h0);
        chk("rst_err_rdata", o_m0_rdata | o_m1_rdata | {30'h0, o_m0_err, o_m1_err}, 32'h0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        // Tie after reset: M0, M1, M0 with both requests held.
        issue(1, 1, 0, 0, 32'h1000_0010, 32'h2000_0020, 0, 0, 4'hF, 4'hF, 0, -1, 32'hA0A0_0001, 1);
        issue(1, 1, 0, 0, 32'h1000_0010, 32'h2000_0020, 0, 0, 4'hF, 4'hF, 1, -1, 32'hA0A0_0002, 1);
        issue(1, 1, 0, 0, 32'h1000_0010, 32'h2000_0020, 0, 0, 4'hF, 4'hF, 0, -1, 32'hA0A0_0003, 1);
        idle(1);
        // Basic read from the bootloader.
        issue(1, 0, 0, 0, 32'h0000_0100, 0, 0, 0, 4'hF, 0, 0, -1, 32'hDEAD_BEEF, 0);
        // Unmapped write by M1.
        issue(0, 1, 0, 1, 0, 32'h8000_0000, 0, 32'h5555_AAAA, 0, 4'hF, 0, -1, 32'h0, 0);
        // Timeout on gpio, followed by late acks while idle.
        issue(0, 1, 0, 0, 0, 32'h4000_0000, 0, 0, 0, 4'hF, 99, 2, 32'h0, 0);
        idle(2);
        // Write to hex with a stray gpu ack, real ack on the last allowed cycle.
        issue(1, 0, 1, 0, 32'h5000_0004, 0, 32'h1234_5678, 0, 4'b0011, 0, 3, 1, 32'hFFFF_FFFF, 0);
        // Decode boundaries.
        issue(1, 0, 0, 0, 32'h0000_1FFC, 0, 0, 0, 4'hF, 0, 0, -1, 32'h0BAD_F00D, 0);
        issue(1, 0, 0, 0, 32'h0000_2000, 0, 0, 0, 4'hF, 0, 0, -1, 32'h0, 0);
        issue(0, 1, 0, 0, 0, 32'h6FFF_FFFC, 0, 0, 0, 4'hF, 2, 0, 32'h7777_1234, 0);
        issue(0, 1, 0, 0, 0, 32'h7000_0000, 0, 0, 0, 4'hF, 0, -1, 32'h0, 0);
        idle(1);

        // Reset during ACCESS aborts the transaction and restores M1 as last served.
        @(posedge i_clk); #1;
        i_m0_req = 1'b1; i_m1_req = 1'b0; i_m0_addr = 32'h1000_0000; i_m0_we = 1'b0; i_ack = '0;
        @(posedge i_clk); #1;
        i_m0_req = 1'b0; i_rst = 1'b1;
        @(negedge i_clk);
        chk("pre_rst_sel", 32'(o_sel), 32'h2);
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_ack = 7'h7F;
        @(negedge i_clk);
        chk("post_rst_sel", 32'(o_sel), 32'h0);
        chk("post_rst_done", {30'h0, o_m0_done, o_m1_done}, 32'h0);
        chk("post_rst_addr", o_addr, 32'h0);
        rr_last = 1;
        idle(2);
        issue(1, 1, 0, 0, 32'h3000_0040, 32'h0000_0040, 0, 0, 4'h1, 4'h2, 1, -1, 32'hC0DE_0001, 0);

        // Randomized traffic.
        for (int t = 0; t < 250; t++) begin
            a   = $urandom;
            cat = $urandom_range(0, 5);
            case (cat)
                0: a = a & 32'h0000_1FFF;
                1: a = {4'($urandom_range(1, 6)), a[27:0]};
                2: a = {4'($urandom_range(1, 6)), a[27:0]};
                3: a = (a[0]) ? 32'h0000_2000 : 32'h0FFF_FFFF;
                4: a = {4'($urandom_range(7, 15)), a[27:0]};
                default: ;
            endcase
            r0 = 1'($urandom); r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            ackd = $urandom_range(0, 5);
            if (ackd == 5) ackd = 99;
            hold = (t % 10 == 0);
            issue(r0, r1, 1'($urandom), 1'($urandom),
                  a, (cat == 5) ? 32'h0000_0004 : {a[31:28], 28'($urandom)},
                  $urandom, $urandom, 4'($urandom), 4'($urandom),
                  ackd, $urandom_range(0, 3), $urandom, hold);
            gap = hold ? 0 : $urandom_range(0, 2);
            if (gap > 0) idle(gap);
        end
        idle(3);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL missing_done: got %0d outstanding responses, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
